// File: rtl/alu_deserializer_pkg.sv
// alu_pkg: shared opcodes, error flag indices, word FSM states and the CRC4 used by the deserializer.
package alu_pkg;
  localparam int DATA_WORDS = 8;
  localparam int WORD_BITS = 11;
  localparam int ERR_DATA = 2;
  localparam int ERR_CRC = 1;
  localparam int ERR_OP = 0;
  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b100,
    SUB = 3'b101
  } operation_t;
  typedef enum logic {W_IDLE, W_SHIFT} word_state_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op inside {AND, OR, ADD, SUB};
  endfunction
  // x^4+x+1, init 0, MSB first over {B, A, 1'b1, OP}
  function automatic logic [3:0] crc4_68(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [67:0] m;
    logic [3:0] c;
    m = {b, a, 1'b1, op};
    c = '0;
    for (int i = 67; i >= 0; i--) c = {c[2:0], 1'b0} ^ ((c[3] ^ m[i]) ? 4'h3 : 4'h0);
    return c;
  endfunction
endpackage

// File: rtl/alu_deserializer_if.sv
// alu_deserializer_if: serial input and decoded operand/error outputs of the deserializer.
interface alu_deserializer_if;
  logic sin;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [2:0] op_out;
  logic data_valid;
  logic err_valid;
  logic [2:0] err_flags;
  modport master(output sin, input a_out, b_out, op_out, data_valid, err_valid, err_flags);
  modport slave(input sin, output a_out, b_out, op_out, data_valid, err_valid, err_flags);
endinterface

// File: rtl/alu_deser_word.sv
// alu_deser_word: frames 11-bit serial words and reports each one as a payload or a framing error.
module alu_deser_word
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       word_valid,
  output logic       word_type,
  output logic [7:0] word_payload,
  output logic       frame_err
);
  word_state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [9:0] sr;
  logic done;
  always_comb begin
    done = state == W_SHIFT && bit_cnt == 4'(WORD_BITS - 1);
    state_n = state == W_IDLE ? (sin ? W_IDLE : W_SHIFT) : (done ? W_IDLE : W_SHIFT);
    bit_cnt_n = state == W_IDLE ? (sin ? 4'd0 : 4'd1) : (done ? 4'd0 : bit_cnt + 4'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= W_IDLE;
      bit_cnt <= '0;
      sr <= '0;
      word_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      if (state == W_SHIFT) sr <= {sr[8:0], sin};
      word_valid <= done && sin;
      frame_err <= done && !sin;
    end
  end
  // the start bit is never stored: sr holds {type, payload, stop} once a word completes
  assign word_type = sr[9];
  assign word_payload = sr[8:1];
endmodule

// File: rtl/alu_deserializer.sv
// alu_deserializer: collects 8 data bytes into {B,A}, validates the control word and emits one op or error pulse.
module alu_deserializer
  import alu_pkg::*;
(
  input logic clk,
  input logic rst,
  alu_deserializer_if.slave bus
);
  logic word_valid, word_type, frame_err;
  logic [7:0] word_payload;
  logic [3:0] byte_cnt;
  logic [63:0] ba;
  logic [2:0] op, flags;
  logic ctl, data_err, crc_err, op_err, err_ev, data_ev;
  alu_deser_word u_word (
    .clk,
    .rst,
    .sin(bus.sin),
    .word_valid,
    .word_type,
    .word_payload,
    .frame_err
  );
  always_comb begin
    op = word_payload[6:4];
    ctl = word_valid && word_type;
    data_err = frame_err || byte_cnt != 4'(DATA_WORDS);
    crc_err = word_payload[3:0] != crc4_68(ba[31:0], ba[63:32], op);
    op_err = !op_legal(op);
    flags = '0;
    flags[ERR_DATA] = data_err;
    flags[ERR_CRC] = !data_err && crc_err;
    flags[ERR_OP] = !data_err && !crc_err && op_err;
    err_ev = frame_err || (ctl && |flags);
    data_ev = ctl && !(|flags);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      ba <= '0;
      bus.a_out <= '0;
      bus.b_out <= '0;
      bus.op_out <= '0;
      bus.data_valid <= 1'b0;
      bus.err_valid <= 1'b0;
      bus.err_flags <= '0;
    end else begin
      bus.data_valid <= data_ev;
      bus.err_valid <= err_ev;
      if (err_ev) bus.err_flags <= flags;
      if (data_ev) begin
        bus.a_out <= ba[31:0];
        bus.b_out <= ba[63:32];
        bus.op_out <= op;
      end
      if (word_valid && !word_type) ba <= {ba[55:0], word_payload};
      // saturating at DATA_WORDS+1 is enough to flag any overlong packet
      byte_cnt <= (frame_err || ctl) ? 4'd0 :
                  (word_valid && byte_cnt < 4'(DATA_WORDS + 1)) ? byte_cnt + 4'd1 : byte_cnt;
    end
  end
endmodule

// File: tb/tb_alu_deserializer.sv
// tb_alu_deserializer: random and directed packets scored against a byte-queue model of the packet rules.
module tb_alu_deserializer;
  import alu_pkg::*;
  typedef struct {
    int due;
    logic dv;
    logic [2:0] flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0] op;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  logic rst_q = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] bq[$];
  ev_t exq[$];
  logic [31:0] m_a = '0, m_b = '0;
  logic [2:0] m_op = '0;
  alu_deserializer_if bus ();
  alu_deserializer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  // remainder of ({B,A,1,OP} * x^4) divided by x^4+x+1
  function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction
  always @(negedge clk) begin
    ev_t e;
    if (rst_q) begin
      exq.delete();
      m_a = '0;
      m_b = '0;
      m_op = '0;
      check("rst_pulses", {bus.data_valid, bus.err_valid}, 0);
      check("rst_err_flags", bus.err_flags, 0);
    end else begin
      check("pulse_exclusive", bus.data_valid && bus.err_valid, 0);
      if (exq.size() > 0 && exq[0].due == cyc) begin
        e = exq.pop_front();
        check("data_valid", bus.data_valid, e.dv);
        check("err_valid", bus.err_valid, !e.dv);
        if (!e.dv) check("err_flags", bus.err_flags, e.flags);
        else begin
          m_a = e.a;
          m_b = e.b;
          m_op = e.op;
        end
      end else check("unexpected_pulse", {bus.data_valid, bus.err_valid}, 0);
    end
    check("a_out", bus.a_out, m_a);
    check("b_out", bus.b_out, m_b);
    check("op_out", bus.op_out, m_op);
  end
  task automatic bit_out(input logic b);
    bus.sin = b;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_ev(input logic dv, input logic [2:0] flags, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    ev_t e;
    e.due = cyc + 1;
    e.dv = dv;
    e.flags = flags;
    e.a = a;
    e.b = b;
    e.op = op;
    exq.push_back(e);
  endtask
  task automatic send_word(input logic t, input logic [7:0] p, input logic stop);
    logic [10:0] w;
    logic [63:0] ba;
    logic [2:0] op;
    w = {1'b0, t, p, stop};
    for (int i = 10; i >= 0; i--) bit_out(w[i]);
    op = p[6:4];
    if (!stop) begin
      bq.delete();
      expect_ev(1'b0, 3'b100, 0, 0, 0);
    end else if (!t) bq.push_back(p);
    else begin
      ba = '0;
      foreach (bq[k]) ba = {ba[55:0], bq[k]};
      if (bq.size() != 8) expect_ev(1'b0, 3'b100, 0, 0, 0);
      else if (p[3:0] != ref_crc(ba[31:0], ba[63:32], op)) expect_ev(1'b0, 3'b010, 0, 0, 0);
      else if (!(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5)) expect_ev(1'b0, 3'b001, 0, 0, 0);
      else expect_ev(1'b1, 3'b000, ba[31:0], ba[63:32], op);
      bq.delete();
    end
  endtask
  task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                             input logic [3:0] crc, input int nw, input int bad);
    logic [63:0] ba;
    int j;
    ba = {b, a};
    for (int k = 0; k < nw; k++) begin
      j = k - (nw > 8 ? nw - 8 : 0);
      send_word(1'b0, j < 0 ? 8'($urandom) : ba[63-8*j -: 8], k != bad);
      if (k == bad) return;
    end
    send_word(1'b1, {1'b0, op, crc}, 1'b1);
  endtask
  task automatic good_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
    send_packet(b, a, op, ref_crc(a, b, op), 8, -1);
  endtask
  task automatic idle(input int n);
    repeat (n) bit_out(1'b1);
  endtask
  initial begin
    logic [31:0] a, b;
    logic [2:0] op;
    logic [3:0] crc;
    logic [10:0] w;
    int r;
    bus.sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    send_packet(0, 0, AND, 4'b1011, 8, -1);
    idle(2);
    send_packet(0, 0, ADD, 4'b0111, 8, -1);
    idle(1);
    send_packet(0, 0, ADD, 4'b0110, 8, -1);
    idle(2);
    send_packet(32'h0bad_f00d, 32'h0000_0042, OR, ref_crc(32'h0000_0042, 32'h0bad_f00d, OR), 7, -1);
    idle(1);
    send_packet(32'hcafe_babe, 32'h1357_9bdf, SUB, ref_crc(32'h1357_9bdf, 32'hcafe_babe, SUB), 9, -1);
    idle(1);
    good_packet(32'h8765_4321, 32'h0f0f_0f0f, ADD);
    idle(2);
    good_packet(32'h1234_5678, 32'hffff_ffff, 3'b010);
    idle(2);
    send_packet(32'h1111_2222, 32'h3333_4444, AND, ref_crc(32'h3333_4444, 32'h1111_2222, AND), 8, 3);
    good_packet(32'hdead_beef, 32'h0123_4567, SUB);
    idle(3);
    for (int k = 0; k < 8; k++) send_word(1'b0, 8'($urandom), 1'b1);
    w = {1'b0, 1'b1, 1'b0, ADD, 4'h5, 1'b1};
    for (int i = 10; i >= 6; i--) bit_out(w[i]);
    bus.sin = w[5];
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.sin = 1'b1;
    bq.delete();
    idle(3);
    good_packet(32'h5a5a_a5a5, 32'h0000_ffff, OR);
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      op = 3'($urandom);
      crc = ref_crc(a, b, op);
      if (r == 0) crc = crc ^ 4'($urandom_range(1, 15));
      send_packet(b, a, op, crc, r == 1 ? 7 : r == 2 ? 9 : 8, r == 3 ? $urandom_range(0, 7) : -1);
    end
    idle(5);
    check("pending_events", 64'(exq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
